// File: rtl/div_share_ctrl_pkg.sv
// div_share_ctrl_pkg: shared FSM encoding and width helper for the divider-sharing controller
package div_share_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr with wrap
module rr_arbiter
  import div_share_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_vld
);
  int s;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    s = 0;
    for (int k = 0; k < NREQ; k++) begin
      s = int'(ptr) + k;
      if (s >= NREQ) s = s - NREQ;
      if (!grant_vld && req[IW'(s)]) begin
        grant_vld = 1'b1;
        grant_idx = IW'(s);
      end
    end
    grant[grant_idx] = grant_vld;
  end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sharing of one combinational divider among NREQ requesters
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic                  rsp_divzero,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic [WIDTH-1:0]      div_quotient,
  output logic                  busy
);
  localparam int IW = clog2_min1(NREQ);
  localparam int CW = clog2_min1(SETTLE);
  localparam logic [WIDTH-1:0] DIVZERO_Q = '1;
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
  logic [WIDTH-1:0] rsp_quotient_q, rsp_quotient_d;
  logic rsp_divzero_q, rsp_divzero_d;
  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0] arb_idx;
  logic arb_vld;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .grant(arb_grant),
    .grant_idx(arb_idx),
    .grant_vld(arb_vld)
  );
  assign sel_dividend = req_dividend[int'(arb_idx)*WIDTH +: WIDTH];
  assign sel_divisor = req_divisor[int'(arb_idx)*WIDTH +: WIDTH];
  assign req_ready = (state_q == IDLE && !rst) ? arb_grant : '0;
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << own_q) : '0;
  assign rsp_quotient = rsp_quotient_q;
  assign rsp_divzero = rsp_divzero_q;
  assign div_dividend = div_dividend_q;
  assign div_divisor = div_divisor_q;
  assign busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    cnt_d = cnt_q;
    div_dividend_d = div_dividend_q;
    div_divisor_d = div_divisor_q;
    rsp_quotient_d = rsp_quotient_q;
    rsp_divzero_d = rsp_divzero_q;
    case (state_q)
      IDLE: if (arb_vld) begin
        own_d = arb_idx;
        ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
        if (sel_divisor == '0) begin
          rsp_quotient_d = DIVZERO_Q;
          rsp_divzero_d = 1'b1;
          state_d = RESP;
        end else begin
          div_dividend_d = sel_dividend;
          div_divisor_d = sel_divisor;
          cnt_d = CW'(SETTLE - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          rsp_quotient_d = div_quotient;
          rsp_divzero_d = 1'b0;
          state_d = RESP;
        end
      end
      RESP: state_d = rsp_ready[own_q] ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      own_q <= '0;
      cnt_q <= '0;
      div_dividend_q <= '0;
      div_divisor_q <= '0;
      rsp_quotient_q <= '0;
      rsp_divzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      div_dividend_q <= div_dividend_d;
      div_divisor_q <= div_divisor_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_divzero_q <= rsp_divzero_d;
    end
  end
endmodule
